usb_data_buffer: RTL and testbench

- 64-byte FIFO shared by the AHB-lite register side and the USB RX/TX packet engines.
- Sits directly downstream of the value register block:
  - consumes its store_tx_data/tx_data, get_rx_data and clear strobes;
  - returns rx_data and buffer_occupancy to it.
- The USB side fills the buffer from received DATA packets and drains it into transmitted DATA packets.
- Single buffer, first-word-fall-through reads, one push and one pop possible per cycle.

---
 rtl/usb_buffer_pkg.sv | 12 +
 rtl/usb_buffer_ptr.sv | 29 ++
 rtl/usb_data_buffer.sv | 111 +++++++++++
 tb/tb_usb_data_buffer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_buffer_pkg.sv
// Shared sizing and types for the USB data buffer.
// Pointers carry one extra bit to tell full from empty.
package usb_buffer_pkg;

  localparam int BUF_DEPTH  = 64;
  localparam int BUF_ADDR_W = 6;
  localparam int BUF_DATA_W = 8;

  typedef logic [BUF_ADDR_W:0] ptr_t;
  typedef logic [BUF_ADDR_W:0] occ_t;

endpackage

// File: rtl/usb_buffer_ptr.sv
// Wrapping pointer counter for the USB data buffer.
// Async reset, sync clear (dominant) and count enable.
import usb_buffer_pkg::*;

module usb_buffer_ptr #(
  parameter int W = BUF_ADDR_W + 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/usb_data_buffer.sv
// 64-byte FWFT FIFO between the AHB register side and
// the USB RX/TX packet engines.
import usb_buffer_pkg::*;

module usb_data_buffer #(
  parameter int DEPTH  = BUF_DEPTH,
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = BUF_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              get_rx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W:0]   w_wptr;
  logic [ADDR_W:0]   w_rptr;
  logic              w_flush;
  logic              w_empty;
  logic              w_full;
  logic              w_push_req;
  logic              w_pop_req;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_din;
  logic [DATA_W-1:0] w_head;

  assign w_flush    = clear | flush;
  assign w_push_req = store_tx_data | store_rx_packet_data;
  assign w_pop_req  = get_rx_data | get_tx_packet_data;

  // RX packet engine wins a same-cycle push collision
  assign w_din = store_rx_packet_data ? rx_packet_data
                                      : tx_data;

  assign w_empty = (w_wptr == w_rptr);
  assign w_full  =
    (w_wptr[ADDR_W] != w_rptr[ADDR_W]) &&
    (w_wptr[ADDR_W-1:0] == w_rptr[ADDR_W-1:0]);

  assign w_pop  = w_pop_req & ~w_empty;
  assign w_push = w_push_req & (~w_full | w_pop);

  usb_buffer_ptr #(.W(ADDR_W + 1)) u_wptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (w_flush),
    .i_en    (w_push),
    .o_count (w_wptr)
  );

  usb_buffer_ptr #(.W(ADDR_W + 1)) u_rptr (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (w_flush),
    .i_en    (w_pop),
    .o_count (w_rptr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !w_flush) begin
      r_mem[w_wptr[ADDR_W-1:0]] <= w_din;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_flush) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_pop_req && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign w_head = w_empty ? '0
                          : r_mem[w_rptr[ADDR_W-1:0]];

  assign rx_data          = w_head;
  assign tx_packet_data   = w_head;
  assign buffer_occupancy = w_wptr - w_rptr;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed self-checking bench for usb_data_buffer.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       clear = 1'b0;
  logic       flush = 1'b0;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       get_rx_data = 1'b0;
  logic [7:0] rx_data;
  logic       store_rx_packet_data = 1'b0;
  logic [7:0] rx_packet_data = 8'h00;
  logic       get_tx_packet_data = 1'b0;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       overflow_err;
  logic       underflow_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .flush                (flush),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #1;
    n_rst = 1'b0;
    #20;
    total++;
    if (buffer_occupancy !== 7'd0) begin
      bad++;
      $display("FAIL reset_occ got=%0d exp=0", buffer_occupancy);
    end
    total++;
    if (rx_data !== 8'h00 || tx_packet_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%h/%h exp=00/00",
               rx_data, tx_packet_data);
    end
    total++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b%b exp=00",
               overflow_err, underflow_err);
    end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_ahb_fill();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      store_tx_data = 1'b1;
      tx_data = d;
      total++;
      if (buffer_occupancy !== 7'(i)) begin
        bad++;
        $display("FAIL fill_occ_pre got=%0d exp=%0d",
                 buffer_occupancy, i);
      end
      tick();
      store_tx_data = 1'b0;
      total++;
      if (buffer_occupancy !== 7'(i + 1)) begin
        bad++;
        $display("FAIL fill_occ got=%0d exp=%0d",
                 buffer_occupancy, i + 1);
      end
      total++;
      if (rx_data !== 8'h11) begin
        bad++;
        $display("FAIL fill_head got=%h exp=11", rx_data);
      end
    end
  endtask

  task automatic test_ahb_drain();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      get_rx_data = 1'b1;
      total++;
      if (rx_data !== d) begin
        bad++;
        $display("FAIL drain_rx got=%h exp=%h", rx_data, d);
      end
      tick();
      get_rx_data = 1'b0;
    end
    total++;
    if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL drain_end got=%0d/%h exp=0/00",
               buffer_occupancy, rx_data);
    end
    total++;
    if (underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL drain_unf got=%b exp=0", underflow_err);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 64; i++) begin
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'(i);
      tick();
    end
    total++;
    if (buffer_occupancy !== 7'd64 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL ovf_full got=%0d/%b exp=64/0",
               buffer_occupancy, overflow_err);
    end
    rx_packet_data = 8'hAA;
    tick();
    store_rx_packet_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd64 || overflow_err !== 1'b1) begin
      bad++;
      $display("FAIL ovf_push got=%0d/%b exp=64/1",
               buffer_occupancy, overflow_err);
    end
    for (int i = 0; i < 64; i++) begin
      get_tx_packet_data = 1'b1;
      total++;
      if (tx_packet_data !== 8'(i)) begin
        bad++;
        $display("FAIL ovf_drain got=%h exp=%h",
                 tx_packet_data, 8'(i));
      end
      tick();
    end
    get_tx_packet_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin
      bad++;
      $display("FAIL ovf_empty got=%0d/%h exp=0/00",
               buffer_occupancy, tx_packet_data);
    end
    total++;
    if (overflow_err !== 1'b1 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL ovf_sticky got=%b%b exp=10",
               overflow_err, underflow_err);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) begin
        store_tx_data = 1'b1;
        tx_data = 8'(r * 40 + i + 1);
        tick();
        total++;
        if (buffer_occupancy !== 7'(i + 1)) begin
          bad++;
          $display("FAIL wrap_push_occ got=%0d exp=%0d",
                   buffer_occupancy, i + 1);
        end
      end
      store_tx_data = 1'b0;
      for (int i = 0; i < 40; i++) begin
        d = 8'(r * 40 + i + 1);
        get_rx_data = 1'b1;
        total++;
        if (rx_data !== d) begin
          bad++;
          $display("FAIL wrap_data got=%h exp=%h", rx_data, d);
        end
        tick();
        total++;
        if (buffer_occupancy !== 7'(39 - i)) begin
          bad++;
          $display("FAIL wrap_pop_occ got=%0d exp=%0d",
                   buffer_occupancy, 39 - i);
        end
      end
      get_rx_data = 1'b0;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear_ovf got=%b exp=0", overflow_err);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d;
    for (int i = 0; i < 64; i++) begin
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'(8'h80 + i);
      tick();
    end
    rx_packet_data = 8'hC5;
    get_tx_packet_data = 1'b1;
    total++;
    if (tx_packet_data !== 8'h80) begin
      bad++;
      $display("FAIL fpp_head got=%h exp=80", tx_packet_data);
    end
    tick();
    store_rx_packet_data = 1'b0;
    get_tx_packet_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd64 || overflow_err !== 1'b0) begin
      bad++;
      $display("FAIL fpp_occ got=%0d/%b exp=64/0",
               buffer_occupancy, overflow_err);
    end
    for (int i = 0; i < 64; i++) begin
      d = (i < 63) ? 8'(8'h81 + i) : 8'hC5;
      get_tx_packet_data = 1'b1;
      total++;
      if (tx_packet_data !== d) begin
        bad++;
        $display("FAIL fpp_drain got=%h exp=%h",
                 tx_packet_data, d);
      end
      tick();
    end
    get_tx_packet_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd0) begin
      bad++;
      $display("FAIL fpp_end got=%0d exp=0", buffer_occupancy);
    end
  endtask

  task automatic test_priority();
    store_rx_packet_data = 1'b1;
    rx_packet_data = 8'h5A;
    store_tx_data = 1'b1;
    tx_data = 8'hA5;
    tick();
    store_rx_packet_data = 1'b0;
    tx_data = 8'h66;
    tick();
    store_tx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd2 || rx_data !== 8'h5A) begin
      bad++;
      $display("FAIL prio got=%0d/%h exp=2/5a",
               buffer_occupancy, rx_data);
    end
    get_rx_data = 1'b1;
    get_tx_packet_data = 1'b1;
    total++;
    if (tx_packet_data !== 8'h5A) begin
      bad++;
      $display("FAIL dual_pop_head got=%h exp=5a", tx_packet_data);
    end
    tick();
    get_tx_packet_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd1 || rx_data !== 8'h66) begin
      bad++;
      $display("FAIL dual_pop got=%0d/%h exp=1/66",
               buffer_occupancy, rx_data);
    end
    tick();
    get_rx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd0 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL prio_end got=%0d/%b exp=0/0",
               buffer_occupancy, underflow_err);
    end
  endtask

  task automatic test_empty_push_pop();
    get_rx_data = 1'b1;
    store_tx_data = 1'b1;
    tx_data = 8'h77;
    tick();
    get_rx_data = 1'b0;
    store_tx_data = 1'b0;
    total++;
    if (underflow_err !== 1'b1 || buffer_occupancy !== 7'd1) begin
      bad++;
      $display("FAIL epp got=%b/%0d exp=1/1",
               underflow_err, buffer_occupancy);
    end
    total++;
    if (rx_data !== 8'h77) begin
      bad++;
      $display("FAIL epp_head got=%h exp=77", rx_data);
    end
    get_rx_data = 1'b1;
    tick();
    get_rx_data = 1'b0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) begin
      store_tx_data = 1'b1;
      tx_data = 8'(8'hE0 + i);
      tick();
    end
    total++;
    if (buffer_occupancy !== 7'd10 || underflow_err !== 1'b1) begin
      bad++;
      $display("FAIL clr_pre got=%0d/%b exp=10/1",
               buffer_occupancy, underflow_err);
    end
    clear = 1'b1;
    tx_data = 8'hEE;
    tick();
    clear = 1'b0;
    store_tx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL clr_occ got=%0d/%h exp=0/00",
               buffer_occupancy, rx_data);
    end
    total++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL clr_flags got=%b%b exp=00",
               overflow_err, underflow_err);
    end
    for (int i = 0; i < 3; i++) begin
      store_rx_packet_data = 1'b1;
      rx_packet_data = 8'(8'h20 + i);
      tick();
    end
    store_rx_packet_data = 1'b0;
    flush = 1'b1;
    get_rx_data = 1'b1;
    tick();
    flush = 1'b0;
    get_rx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd0) begin
      bad++;
      $display("FAIL flush_occ got=%0d exp=0", buffer_occupancy);
    end
    store_tx_data = 1'b1;
    tx_data = 8'h3C;
    tick();
    store_tx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd1 || rx_data !== 8'h3C) begin
      bad++;
      $display("FAIL flush_after got=%0d/%h exp=1/3c",
               buffer_occupancy, rx_data);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      store_tx_data = 1'b1;
      tx_data = 8'(8'h30 + i);
      tick();
    end
    tx_data = 8'h99;
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (buffer_occupancy !== 7'd0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL rmid_occ got=%0d/%h exp=0/00",
               buffer_occupancy, rx_data);
    end
    total++;
    if (tx_packet_data !== 8'h00 ||
        overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      bad++;
      $display("FAIL rmid_out got=%h/%b%b exp=00/00",
               tx_packet_data, overflow_err, underflow_err);
    end
    #10;
    store_tx_data = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    total++;
    if (buffer_occupancy !== 7'd0) begin
      bad++;
      $display("FAIL rmid_hold got=%0d exp=0", buffer_occupancy);
    end
    store_tx_data = 1'b1;
    tx_data = 8'h42;
    tick();
    store_tx_data = 1'b0;
    total++;
    if (buffer_occupancy !== 7'd1 || rx_data !== 8'h42) begin
      bad++;
      $display("FAIL rmid_after got=%0d/%h exp=1/42",
               buffer_occupancy, rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_ahb_fill();
    test_ahb_drain();
    test_overflow();
    test_wrap();
    test_full_push_pop();
    test_priority();
    test_empty_push_pop();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
